// File: rtl/vlsu_axi_order_ctrl.sv
// Read/write ordering controller for the vector LSU AXI port: keeps AR and AW
// traffic mutually exclusive and hands the bus over after a fairness budget.
module vlsu_axi_order_ctrl #(
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned SwitchBudget   = 4,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ar_valid_i,
  output logic            ar_ready_o,
  output logic            ar_valid_o,
  input  logic            ar_ready_i,
  input  logic            aw_valid_i,
  output logic            aw_ready_o,
  output logic            aw_valid_o,
  input  logic            aw_ready_i,
  input  logic            r_valid_i,
  input  logic            r_ready_i,
  input  logic            r_last_i,
  input  logic            b_valid_i,
  input  logic            b_ready_i,
  output logic [CntW-1:0] rd_cnt_o,
  output logic [CntW-1:0] wr_cnt_o,
  output logic [2:0]      mode_o,
  output logic            err_o
);

  localparam int unsigned BW = $clog2(SwitchBudget + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [BW:0]     BudgetW = (BW + 1)'(SwitchBudget);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_DRAIN_R = 3'd2,
    S_WRITE   = 3'd3,
    S_DRAIN_W = 3'd4
  } mode_e;

  mode_e           state, state_d;
  logic [CntW-1:0] rd_cnt, rd_cnt_d, wr_cnt, wr_cnt_d;
  logic [BW-1:0]   bcnt, bcnt_d;
  logic [BW:0]     bcnt_eff;
  logic            last_read, last_read_d;
  logic            err, err_d;
  logic            ar_gate, aw_gate;
  logic            ar_issue, aw_issue, r_done, b_done;
  logic            rd_uflow, wr_uflow, spend;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high. Each gate masks valid and ready of one channel together, so
  // when open the AXI cut sees the addrgen handshake unchanged, same cycle.
  assign ar_gate    = !rst_i && (state == S_READ)  && (rd_cnt < MaxCnt);
  assign aw_gate    = !rst_i && (state == S_WRITE) && (wr_cnt < MaxCnt);
  assign ar_valid_o = ar_valid_i && ar_gate;
  assign ar_ready_o = ar_ready_i && ar_gate;
  assign aw_valid_o = aw_valid_i && aw_gate;
  assign aw_ready_o = aw_ready_i && aw_gate;

  assign ar_issue = ar_valid_o && ar_ready_i;
  assign aw_issue = aw_valid_o && aw_ready_i;
  assign r_done   = r_valid_i && r_ready_i && r_last_i;
  assign b_done   = b_valid_i && b_ready_i;

  always_comb begin
    rd_cnt_d = rd_cnt;
    rd_uflow = 1'b0;
    if (ar_issue && !r_done) begin
      rd_cnt_d = rd_cnt + CntW'(1);
    end else if (r_done && !ar_issue) begin
      if (rd_cnt == '0) rd_uflow = 1'b1;
      else              rd_cnt_d = rd_cnt - CntW'(1);
    end
    wr_cnt_d = wr_cnt;
    wr_uflow = 1'b0;
    if (aw_issue && !b_done) begin
      wr_cnt_d = wr_cnt + CntW'(1);
    end else if (b_done && !aw_issue) begin
      if (wr_cnt == '0) wr_uflow = 1'b1;
      else              wr_cnt_d = wr_cnt - CntW'(1);
    end
  end

  // The budget compare includes the issue happening this cycle, so the mode
  // yields right after the budget-th burst granted while the other side waits.
  always_comb begin
    state_d     = state;
    last_read_d = last_read;
    spend       = 1'b0;
    unique case (state)
      S_READ:  spend = ar_issue && aw_valid_i;
      S_WRITE: spend = aw_issue && ar_valid_i;
      default: spend = 1'b0;
    endcase
    bcnt_eff = {1'b0, bcnt} + {{BW{1'b0}}, spend};

    unique case (state)
      S_IDLE: begin
        if (ar_valid_i && aw_valid_i) state_d = last_read ? S_WRITE : S_READ;
        else if (ar_valid_i)          state_d = S_READ;
        else if (aw_valid_i)          state_d = S_WRITE;
      end
      S_READ: begin
        last_read_d = 1'b1;
        if (!(ar_valid_o && !ar_ready_i) &&
            ((aw_valid_i && (bcnt_eff >= BudgetW || !ar_valid_i)) ||
             (!ar_valid_i && !aw_valid_i && rd_cnt == '0)))
          state_d = S_DRAIN_R;
      end
      S_DRAIN_R: begin
        if (rd_cnt_d == '0) state_d = aw_valid_i ? S_WRITE : S_IDLE;
      end
      S_WRITE: begin
        last_read_d = 1'b0;
        if (!(aw_valid_o && !aw_ready_i) &&
            ((ar_valid_i && (bcnt_eff >= BudgetW || !aw_valid_i)) ||
             (!aw_valid_i && !ar_valid_i && wr_cnt == '0)))
          state_d = S_DRAIN_W;
      end
      S_DRAIN_W: begin
        if (wr_cnt_d == '0) state_d = ar_valid_i ? S_READ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state)        bcnt_d = '0;
    else if (bcnt_eff >= BudgetW) bcnt_d = BudgetW[BW-1:0];
    else                          bcnt_d = bcnt_eff[BW-1:0];

    err_d = err || rd_uflow || wr_uflow ||
            (state == S_DRAIN_R && wr_cnt != '0) ||
            (state == S_DRAIN_W && rd_cnt != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      bcnt      <= '0;
      err       <= 1'b0;
      last_read <= 1'b0;
    end else begin
      state     <= state_d;
      rd_cnt    <= rd_cnt_d;
      wr_cnt    <= wr_cnt_d;
      bcnt      <= bcnt_d;
      err       <= err_d;
      last_read <= last_read_d;
    end
  end

  assign rd_cnt_o = rd_cnt;
  assign wr_cnt_o = wr_cnt;
  assign mode_o   = state;
  assign err_o    = err;

endmodule

// File: tb/tb_vlsu_axi_order_ctrl.sv
// Self-checking bench for vlsu_axi_order_ctrl: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_vlsu_axi_order_ctrl;

  localparam int MAX = 8;
  localparam int BUDGET = 4;
  localparam int M_IDLE = 0, M_READ = 1, M_DR = 2, M_WRITE = 3, M_DW = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       ar_valid_i = 1'b0, ar_ready_i = 1'b0;
  logic       aw_valid_i = 1'b0, aw_ready_i = 1'b0;
  logic       r_valid_i = 1'b0, r_ready_i = 1'b0, r_last_i = 1'b0;
  logic       b_valid_i = 1'b0, b_ready_i = 1'b0;
  logic       ar_ready_o, ar_valid_o, aw_ready_o, aw_valid_o;
  logic [3:0] rd_cnt_o, wr_cnt_o;
  logic [2:0] mode_o;
  logic       err_o;

  int vectors = 0;
  int miscompares = 0;

  vlsu_axi_order_ctrl #(.MaxOutstanding(MAX), .SwitchBudget(BUDGET)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
    .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
    .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o), .mode_o(mode_o), .err_o(err_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural model: which side owns the bus, how many bursts are open
  int m_mode = M_IDLE, m_rd = 0, m_wr = 0, m_b = 0;
  bit m_last_read = 1'b0, m_err = 1'b0;

  always @(posedge clk) begin : model
    bit rd_up, wr_up, rd_dn, wr_dn, mine, other, stuck, own_up;
    int spent, nxt, own_cnt, new_rd, new_wr;
    if (rst_i) begin
      m_mode = M_IDLE; m_rd = 0; m_wr = 0; m_b = 0;
      m_last_read = 1'b0; m_err = 1'b0;
    end else begin
      rd_up = ar_valid_i && ar_ready_i && m_mode == M_READ && m_rd < MAX;
      wr_up = aw_valid_i && aw_ready_i && m_mode == M_WRITE && m_wr < MAX;
      rd_dn = r_valid_i && r_ready_i && r_last_i;
      wr_dn = b_valid_i && b_ready_i;
      new_rd = m_rd + int'(rd_up) - int'(rd_dn);
      new_wr = m_wr + int'(wr_up) - int'(wr_dn);
      if (new_rd < 0) begin new_rd = 0; m_err = 1'b1; end
      if (new_wr < 0) begin new_wr = 0; m_err = 1'b1; end
      if (m_mode == M_DR && m_wr > 0) m_err = 1'b1;
      if (m_mode == M_DW && m_rd > 0) m_err = 1'b1;
      nxt = m_mode;
      spent = m_b;
      if (m_mode == M_READ || m_mode == M_WRITE) begin
        mine    = (m_mode == M_READ) ? ar_valid_i : aw_valid_i;
        other   = (m_mode == M_READ) ? aw_valid_i : ar_valid_i;
        own_cnt = (m_mode == M_READ) ? m_rd : m_wr;
        own_up  = (m_mode == M_READ) ? rd_up : wr_up;
        stuck   = mine && own_cnt < MAX && !((m_mode == M_READ) ? ar_ready_i : aw_ready_i);
        if (own_up && other) spent++;
        if (!stuck && ((other && (spent >= BUDGET || !mine)) || (!mine && !other && own_cnt == 0)))
          nxt = m_mode + 1;
        m_last_read = (m_mode == M_READ);
      end else if (m_mode == M_DR) begin
        if (new_rd == 0) nxt = aw_valid_i ? M_WRITE : M_IDLE;
      end else if (m_mode == M_DW) begin
        if (new_wr == 0) nxt = ar_valid_i ? M_READ : M_IDLE;
      end else begin
        if (ar_valid_i && aw_valid_i) nxt = m_last_read ? M_WRITE : M_READ;
        else if (ar_valid_i)          nxt = M_READ;
        else if (aw_valid_i)          nxt = M_WRITE;
      end
      m_b = (nxt == m_mode) ? spent : 0;
      m_mode = nxt; m_rd = new_rd; m_wr = new_wr;
    end
  end

  // driver tasks
  task automatic clear_inputs();
    ar_valid_i = 0; ar_ready_i = 0; aw_valid_i = 0; aw_ready_i = 0;
    r_valid_i = 0; r_ready_i = 0; r_last_i = 0; b_valid_i = 0; b_ready_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic set_r(input bit v);
    r_valid_i = v; r_ready_i = v; r_last_i = v;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_i = 1'b1;
    ar_valid_i = 1; ar_ready_i = 1; aw_valid_i = 1; aw_ready_i = 1;
    #1;
    vectors++;
    if ({ar_valid_o, ar_ready_o, aw_valid_o, aw_ready_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_gates: got %b expected 0000", {ar_valid_o, ar_ready_o, aw_valid_o, aw_ready_o});
    end
    @(negedge clk); #1;
    vectors++;
    if (mode_o !== 3'd0 || rd_cnt_o !== 4'd0 || wr_cnt_o !== 4'd0 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got mode=%0d rd=%0d wr=%0d err=%0d expected 0 0 0 0",
               mode_o, rd_cnt_o, wr_cnt_o, err_o);
    end
    rst_i = 1'b0;
    clear_inputs();
  endtask

  task automatic test_read_only();
    int n = 0;
    do_reset();
    ar_valid_i = 1; ar_ready_i = 1;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (ar_valid_o && ar_ready_i) n++;
      if (c == 9) begin
        vectors++;
        if (ar_valid_o !== 1'b0) begin
          miscompares++; $display("FAIL read_cycle9_stall: got ar_valid_o=%0d expected 0", ar_valid_o);
        end
      end
      @(negedge clk); #1;
    end
    vectors++;
    if (n != 8 || rd_cnt_o !== 4'd8) begin
      miscompares++; $display("FAIL read_only_count: got ars=%0d rd=%0d expected 8 8", n, rd_cnt_o);
    end
    set_r(1);
    #1;
    vectors++;
    if (ar_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL full_same_cycle: got ar_valid_o=%0d expected 0", ar_valid_o);
    end
    @(negedge clk);
    set_r(0);
    #1;
    vectors++;
    if (ar_valid_o !== 1'b1 || rd_cnt_o !== 4'd7) begin
      miscompares++; $display("FAIL full_next_cycle: got ar_valid_o=%0d rd=%0d expected 1 7", ar_valid_o, rd_cnt_o);
    end
    @(negedge clk);
    ar_valid_i = 0;
    set_r(1);
    repeat (8) @(negedge clk);
    set_r(0);
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (mode_o !== 3'd0 || rd_cnt_o !== 4'd0 || err_o !== 1'b0) begin
      miscompares++; $display("FAIL read_drain_idle: got mode=%0d rd=%0d err=%0d expected 0 0 0", mode_o, rd_cnt_o, err_o);
    end
  endtask

  task automatic test_switch();
    int n = 0;
    do_reset();
    ar_valid_i = 1; ar_ready_i = 1; aw_ready_i = 1;
    @(negedge clk);
    aw_valid_i = 1;
    #1;
    for (int c = 0; c < 20 && mode_o == 3'd1; c++) begin
      if (ar_valid_o && ar_ready_i) n++;
      @(negedge clk); #1;
    end
    vectors++;
    if (n != BUDGET || mode_o !== 3'd2 || rd_cnt_o !== 4'd4) begin
      miscompares++; $display("FAIL switch_budget: got ars=%0d mode=%0d rd=%0d expected 4 2 4", n, mode_o, rd_cnt_o);
    end
    vectors++;
    if (ar_valid_o !== 1'b0 || aw_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL drain_quiet: got ar=%0d aw=%0d expected 0 0", ar_valid_o, aw_valid_o);
    end
    set_r(1);
    repeat (4) @(negedge clk);
    set_r(0);
    #1;
    vectors++;
    if (mode_o !== 3'd3 || aw_valid_o !== 1'b1) begin
      miscompares++; $display("FAIL switch_to_write: got mode=%0d aw_valid_o=%0d expected 3 1", mode_o, aw_valid_o);
    end
    @(negedge clk); #1;
    vectors++;
    if (wr_cnt_o !== 4'd1 || err_o !== 1'b0) begin
      miscompares++; $display("FAIL first_aw: got wr=%0d err=%0d expected 1 0", wr_cnt_o, err_o);
    end
  endtask

  task automatic test_tie();
    do_reset();
    ar_valid_i = 1; aw_valid_i = 1; ar_ready_i = 1; aw_ready_i = 1;
    @(negedge clk); #1;
    vectors++;
    if (mode_o !== 3'd1) begin
      miscompares++; $display("FAIL tie_after_reset: got mode=%0d expected 1", mode_o);
    end
    for (int c = 0; c < 20 && mode_o != 3'd2; c++) begin @(negedge clk); #1; end
    set_r(1);
    for (int c = 0; c < 20 && mode_o == 3'd2; c++) begin @(negedge clk); #1; end
    set_r(0);
    vectors++;
    if (mode_o !== 3'd3 || rd_cnt_o !== 4'd0) begin
      miscompares++; $display("FAIL tie_drain_write: got mode=%0d rd=%0d expected 3 0", mode_o, rd_cnt_o);
    end
    do_reset();
    ar_valid_i = 1;
    @(negedge clk);
    ar_valid_i = 0;
    repeat (2) @(negedge clk);
    ar_valid_i = 1; aw_valid_i = 1;
    @(negedge clk); #1;
    vectors++;
    if (mode_o !== 3'd3) begin
      miscompares++; $display("FAIL tie_after_read: got mode=%0d expected 3", mode_o);
    end
  endtask

  task automatic test_stability();
    do_reset();
    ar_valid_i = 1; ar_ready_i = 1;
    @(negedge clk);
    aw_valid_i = 1;
    repeat (3) @(negedge clk);
    ar_ready_i = 0;
    #1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (mode_o !== 3'd1 || ar_valid_o !== 1'b1) begin
        miscompares++; $display("FAIL ar_held: cycle %0d got mode=%0d ar_valid_o=%0d expected 1 1", k, mode_o, ar_valid_o);
      end
      @(negedge clk); #1;
    end
    ar_ready_i = 1;
    @(negedge clk); #1;
    vectors++;
    if (mode_o !== 3'd2 || rd_cnt_o !== 4'd4) begin
      miscompares++; $display("FAIL leave_after_hs: got mode=%0d rd=%0d expected 2 4", mode_o, rd_cnt_o);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ar_valid_i = 1; ar_ready_i = 1;
    repeat (4) @(negedge clk);
    #1;
    vectors++;
    if (rd_cnt_o !== 4'd3) begin
      miscompares++; $display("FAIL rd_at_3: got %0d expected 3", rd_cnt_o);
    end
    set_r(1);
    @(negedge clk);
    set_r(0);
    ar_valid_i = 0;
    #1;
    vectors++;
    if (rd_cnt_o !== 4'd3 || err_o !== 1'b0) begin
      miscompares++; $display("FAIL issue_and_done: got rd=%0d err=%0d expected 3 0", rd_cnt_o, err_o);
    end
    b_valid_i = 1; b_ready_i = 1;
    @(negedge clk);
    b_valid_i = 0; b_ready_i = 0;
    #1;
    vectors++;
    if (err_o !== 1'b1 || wr_cnt_o !== 4'd0) begin
      miscompares++; $display("FAIL b_underflow: got err=%0d wr=%0d expected 1 0", err_o, wr_cnt_o);
    end
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (err_o !== 1'b1) begin
      miscompares++; $display("FAIL err_sticky: got %0d expected 1", err_o);
    end
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    #1;
    vectors++;
    if (rd_cnt_o !== 4'd0 || err_o !== 1'b0 || mode_o !== 3'd0) begin
      miscompares++; $display("FAIL mid_reset: got rd=%0d err=%0d mode=%0d expected 0 0 0", rd_cnt_o, err_o, mode_o);
    end
    set_r(1);
    @(negedge clk);
    set_r(0);
    #1;
    vectors++;
    if (err_o !== 1'b1) begin
      miscompares++; $display("FAIL late_r_after_reset: got err=%0d expected 1", err_o);
    end
  endtask

  task automatic test_random();
    bit e_arv, e_awv, e_arr, e_awr;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_i      = ($urandom_range(0, 299) == 0);
      ar_valid_i = ($urandom_range(0, 3) != 0);
      aw_valid_i = ($urandom_range(0, 3) != 0);
      ar_ready_i = ($urandom_range(0, 3) != 0);
      aw_ready_i = ($urandom_range(0, 3) != 0);
      r_valid_i  = (m_rd > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      r_ready_i  = ($urandom_range(0, 3) != 0);
      r_last_i   = ($urandom_range(0, 1) == 0);
      b_valid_i  = (m_wr > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      b_ready_i  = ($urandom_range(0, 3) != 0);
      #1;
      e_arv = !rst_i && ar_valid_i && m_mode == M_READ && m_rd < MAX;
      e_arr = !rst_i && ar_ready_i && m_mode == M_READ && m_rd < MAX;
      e_awv = !rst_i && aw_valid_i && m_mode == M_WRITE && m_wr < MAX;
      e_awr = !rst_i && aw_ready_i && m_mode == M_WRITE && m_wr < MAX;
      vectors++;
      if ({ar_valid_o, ar_ready_o, aw_valid_o, aw_ready_o} !== {e_arv, e_arr, e_awv, e_awr}) begin
        miscompares++; $display("FAIL rand_gates: cycle %0d got %b expected %b", c,
          {ar_valid_o, ar_ready_o, aw_valid_o, aw_ready_o}, {e_arv, e_arr, e_awv, e_awr});
      end
      vectors++;
      if (int'(mode_o) != m_mode) begin
        miscompares++; $display("FAIL rand_mode: cycle %0d got %0d expected %0d", c, mode_o, m_mode);
      end
      vectors++;
      if (int'(rd_cnt_o) != m_rd || int'(wr_cnt_o) != m_wr) begin
        miscompares++; $display("FAIL rand_counts: cycle %0d got rd=%0d wr=%0d expected %0d %0d",
                                c, rd_cnt_o, wr_cnt_o, m_rd, m_wr);
      end
      vectors++;
      if (err_o !== m_err) begin
        miscompares++; $display("FAIL rand_err: cycle %0d got %0d expected %0d", c, err_o, m_err);
      end
      vectors++;
      if ((aw_valid_o && rd_cnt_o != 0) || (ar_valid_o && wr_cnt_o != 0)) begin
        miscompares++; $display("FAIL rand_exclusive: cycle %0d got ar=%0d aw=%0d rd=%0d wr=%0d expected no overlap",
                                c, ar_valid_o, aw_valid_o, rd_cnt_o, wr_cnt_o);
      end
      @(negedge clk);
    end
    rst_i = 0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_read_only();
    test_switch();
    test_tie();
    test_stability();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
